// File: rtl/wb_pkg.sv
// Shared types for the MEM->WB stage: one write-back entry (GPR write plus
// CSR write) and the occupancy encoding of the two-slot skid buffer.
// The entry fields are sized to the stage's default widths; the stage
// parameters must not exceed them.
package wb_pkg;
    localparam int WB_XLEN = 64;
    localparam int WB_RA_W = 5;
    localparam int WB_CA_W = 12;

    typedef struct packed {
        logic [WB_RA_W-1:0] rd_addr;
        logic               rd_we;
        logic [WB_XLEN-1:0] rd_data;
        logic [WB_CA_W-1:0] csr_addr;
        logic               csr_we;
        logic [WB_XLEN-1:0] csr_data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_ONE   = 2'd1,
        WB_TWO   = 2'd2
    } wb_state_t;
endpackage

// File: rtl/wb_entry_reg.sv
// One write-back entry slot: load-enabled register with synchronous reset.
module wb_entry_reg
    import wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      ld,
    input  wb_entry_t d,
    output wb_entry_t q
);
    // Hold the entry until loaded; reset clears it.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (ld) q <= d;
    end
endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with valid/ready handshake and a two-slot skid
// buffer (head drives the write ports, skid absorbs one extra entry) so
// that in_ready comes straight from a flop. Synchronous flush empties both
// slots but still lets the head drain in the flush cycle.
// Optional: define MEM_WB_RETIRE_CNT_EN to add the 64-bit retire counter.
module mem_wb_pipe
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int RA_W = WB_RA_W,
    parameter int CA_W = WB_CA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rd_addr,
    input  logic            in_rd_we,
    input  logic [XLEN-1:0] in_rd_data,
    input  logic [CA_W-1:0] in_csr_addr,
    input  logic            in_csr_we,
    input  logic [XLEN-1:0] in_csr_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RA_W-1:0] out_rd_addr,
    output logic [XLEN-1:0] out_rd_data,
    output logic            out_rd_we,
    output logic [CA_W-1:0] out_csr_addr,
    output logic [XLEN-1:0] out_csr_data,
    output logic            out_csr_we
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     retire_cnt
`endif
);
    wb_state_t state_q, state_n;
    logic      in_ready_q, out_valid_q;
    logic      accept, drain;
    logic      head_ld, skid_ld;
    wb_entry_t in_e, head_d, head_q, skid_q;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Pack the incoming fields into an entry.
    always_comb begin
        in_e                     = '0;
        in_e.rd_addr[RA_W-1:0]   = in_rd_addr;
        in_e.rd_we               = in_rd_we;
        in_e.rd_data[XLEN-1:0]   = in_rd_data;
        in_e.csr_addr[CA_W-1:0]  = in_csr_addr;
        in_e.csr_we              = in_csr_we;
        in_e.csr_data[XLEN-1:0]  = in_csr_data;
    end

    // Occupancy transitions and slot load enables; flush drops everything.
    always_comb begin
        state_n = state_q;
        head_ld = 1'b0;
        skid_ld = 1'b0;
        head_d  = in_e;
        if (flush) begin
            state_n = WB_EMPTY;
        end else begin
            case (state_q)
                WB_EMPTY: if (accept) begin
                    state_n = WB_ONE;
                    head_ld = 1'b1;
                end
                WB_ONE: begin
                    if (accept && drain) begin
                        head_ld = 1'b1;
                    end else if (accept) begin
                        state_n = WB_TWO;
                        skid_ld = 1'b1;
                    end else if (drain) begin
                        state_n = WB_EMPTY;
                    end
                end
                WB_TWO: if (drain) begin
                    state_n = WB_ONE;
                    head_ld = 1'b1;
                    head_d  = skid_q;
                end
                default: state_n = WB_EMPTY;
            endcase
        end
    end

    // State plus the handshake flags, registered from the next state so
    // neither output has a combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WB_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            in_ready_q  <= (state_n != WB_TWO);
            out_valid_q <= (state_n != WB_EMPTY);
        end
    end

    wb_entry_reg u_head (.clk(clk), .rst(rst), .ld(head_ld), .d(head_d), .q(head_q));
    wb_entry_reg u_skid (.clk(clk), .rst(rst), .ld(skid_ld), .d(in_e),   .q(skid_q));

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_rd_addr  = head_q.rd_addr[RA_W-1:0];
    assign out_rd_data  = head_q.rd_data[XLEN-1:0];
    assign out_csr_addr = head_q.csr_addr[CA_W-1:0];
    assign out_csr_data = head_q.csr_data[XLEN-1:0];
    // x0 is hard-wired zero, so a write to it is suppressed here.
    assign out_rd_we    = out_valid_q & head_q.rd_we & (head_q.rd_addr[RA_W-1:0] != '0);
    assign out_csr_we   = out_valid_q & head_q.csr_we;

`ifdef MEM_WB_RETIRE_CNT_EN
    // Count every drained entry, including one drained in a flush cycle.
    always_ff @(posedge clk) begin
        if (rst)        retire_cnt <= '0;
        else if (drain) retire_cnt <= retire_cnt + 64'd1;
    end
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a cycle-by-cycle vector table plus
// hand-written sequences for streaming, flush and reset corner cases.
module tb_mem_wb_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd_addr;
    logic        in_rd_we;
    logic [63:0] in_rd_data;
    logic [11:0] in_csr_addr;
    logic        in_csr_we;
    logic [63:0] in_csr_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_addr;
    logic [63:0] out_rd_data;
    logic        out_rd_we;
    logic [11:0] out_csr_addr;
    logic [63:0] out_csr_data;
    logic        out_csr_we;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_rd_data(in_rd_data),
        .in_csr_addr(in_csr_addr), .in_csr_we(in_csr_we), .in_csr_data(in_csr_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data), .out_rd_we(out_rd_we),
        .out_csr_addr(out_csr_addr), .out_csr_data(out_csr_data), .out_csr_we(out_csr_we)
`ifdef MEM_WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic [4:0]  ra;
        logic        we;
        logic [63:0] rd;
        logic [11:0] ca;
        logic        cwe;
        logic [63:0] cd;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic        e_rwe;
        logic [4:0]  e_ra;
        logic [63:0] e_rd;
        logic        e_cwe;
        logic [11:0] e_ca;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [63:0] exp);
`ifdef MEM_WB_RETIRE_CNT_EN
        chk(nm, retire_cnt, exp);
`endif
    endtask

    task automatic drive(input logic v, input logic [4:0] ra, input logic we,
                         input logic [63:0] rd, input logic [11:0] ca, input logic cwe,
                         input logic [63:0] cd, input logic ordy, input logic fl);
        in_valid = v; in_rd_addr = ra; in_rd_we = we; in_rd_data = rd;
        in_csr_addr = ca; in_csr_we = cwe; in_csr_data = cd;
        out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          v  ra   we rd        ca      cwe cd      ordy irdy ovld rwe ra  rd       cwe ca
        vecs[0] = '{1, 5'd5, 1, 64'hDEAD, 12'h0,  0, 64'h0,  1,   1,   1,   1, 5'd5, 64'hDEAD, 0, 12'h0};
        vecs[1] = '{0, 5'd0, 0, 64'h0,    12'h0,  0, 64'h0,  1,   1,   0,   0, 5'd0, 64'h0,    0, 12'h0};
        vecs[2] = '{1, 5'd0, 1, 64'h1234, 12'h300,1, 64'hABC,0,   1,   1,   0, 5'd0, 64'h1234, 1, 12'h300};
        vecs[3] = '{0, 5'd0, 0, 64'h0,    12'h0,  0, 64'h0,  1,   1,   0,   0, 5'd0, 64'h0,    0, 12'h0};
        vecs[4] = '{1, 5'd1, 1, 64'hA1,   12'h0,  0, 64'h0,  0,   1,   1,   1, 5'd1, 64'hA1,   0, 12'h0};
        vecs[5] = '{1, 5'd2, 1, 64'hB2,   12'h0,  0, 64'h0,  0,   0,   1,   1, 5'd1, 64'hA1,   0, 12'h0};
        vecs[6] = '{1, 5'd3, 1, 64'hC3,   12'h0,  0, 64'h0,  0,   0,   1,   1, 5'd1, 64'hA1,   0, 12'h0};
        vecs[7] = '{1, 5'd3, 1, 64'hC3,   12'h0,  0, 64'h0,  1,   1,   1,   1, 5'd2, 64'hB2,   0, 12'h0};
        vecs[8] = '{1, 5'd3, 1, 64'hC3,   12'h0,  0, 64'h0,  1,   1,   1,   1, 5'd3, 64'hC3,   0, 12'h0};
        vecs[9] = '{0, 5'd0, 0, 64'h0,    12'h0,  0, 64'h0,  1,   1,   0,   0, 5'd0, 64'h0,    0, 12'h0};

        // Reset state
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_rd_we",     64'(out_rd_we), 64'd0);
        chk("rst_csr_we",    64'(out_csr_we), 64'd0);
        chk("rst_rd_addr",   64'(out_rd_addr), 64'd0);
        chk("rst_rd_data",   out_rd_data, 64'd0);
        chk("rst_csr_addr",  64'(out_csr_addr), 64'd0);
        chk("rst_csr_data",  out_csr_data, 64'd0);
        chk_cnt("rst_cnt", 64'd0);
        rst = 1'b0;

        // Cycle-by-cycle vectors: single entry, x0 suppression, backpressure A/B/C
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].ra, vecs[i].we, vecs[i].rd,
                  vecs[i].ca, vecs[i].cwe, vecs[i].cd, vecs[i].ordy, 1'b0);
            tick();
            chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].e_irdy));
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ovld));
            chk($sformatf("v%0d_rd_we", i),     64'(out_rd_we), 64'(vecs[i].e_rwe));
            chk($sformatf("v%0d_csr_we", i),    64'(out_csr_we), 64'(vecs[i].e_cwe));
            if (vecs[i].e_ovld) begin
                chk($sformatf("v%0d_rd_addr", i),  64'(out_rd_addr), 64'(vecs[i].e_ra));
                chk($sformatf("v%0d_rd_data", i),  out_rd_data, vecs[i].e_rd);
                chk($sformatf("v%0d_csr_addr", i), 64'(out_csr_addr), 64'(vecs[i].e_ca));
            end
        end
        chk_cnt("vec_cnt", 64'd5);

        // Restart the counter, then stream 8 entries with out_ready held high
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'(i + 1), 1, 64'h100 + 64'(i), 12'h0, 0, 0, 1, 0);
            tick();
            chk($sformatf("bb%0d_in_ready", i),  64'(in_ready), 64'd1);
            chk($sformatf("bb%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bb%0d_rd_addr", i),   64'(out_rd_addr), 64'(i + 1));
            chk($sformatf("bb%0d_rd_data", i),   out_rd_data, 64'h100 + 64'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("bb_end_valid", 64'(out_valid), 64'd0);
        chk_cnt("bb_cnt", 64'd8);

        // Fill to TWO, then flush with out_ready: head drains, skid dropped
        drive(1, 5'd7, 1, 64'h77, 0, 0, 0, 0, 0); tick();
        drive(1, 5'd8, 1, 64'h88, 0, 0, 0, 0, 0); tick();
        chk("fl2_in_ready", 64'(in_ready), 64'd0);
        drive(1, 5'd9, 1, 64'h99, 0, 0, 0, 1, 1); tick();
        chk("fl2_out_valid", 64'(out_valid), 64'd0);
        chk("fl2_in_ready1", 64'(in_ready), 64'd1);
        chk_cnt("fl2_cnt", 64'd9);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        chk("fl2_after_valid", 64'(out_valid), 64'd0);
        chk_cnt("fl2_after_cnt", 64'd9);

        // Flush in ONE without out_ready: head lost, accepted-looking input dropped
        drive(1, 5'd10, 1, 64'hAA, 0, 0, 0, 0, 0); tick();
        chk("fl1_valid", 64'(out_valid), 64'd1);
        drive(1, 5'd11, 1, 64'hBB, 0, 0, 0, 0, 1); tick();
        chk("fl1_out_valid", 64'(out_valid), 64'd0);
        chk("fl1_in_ready",  64'(in_ready), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        chk("fl1_after_valid", 64'(out_valid), 64'd0);
        chk_cnt("fl1_cnt", 64'd9);

        // Reset while in TWO with an input offered during reset
        drive(1, 5'd12, 1, 64'hC0, 12'h305, 1, 64'h1, 0, 0); tick();
        drive(1, 5'd13, 1, 64'hC1, 12'h306, 1, 64'h2, 0, 0); tick();
        chk("rs_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        drive(1, 5'd14, 1, 64'hC2, 12'h307, 1, 64'h3, 1, 0); tick();
        rst = 1'b0;
        chk("rs_out_valid", 64'(out_valid), 64'd0);
        chk("rs_in_ready1", 64'(in_ready), 64'd1);
        chk("rs_rd_addr",   64'(out_rd_addr), 64'd0);
        chk("rs_rd_data",   out_rd_data, 64'd0);
        chk("rs_csr_addr",  64'(out_csr_addr), 64'd0);
        chk("rs_csr_data",  out_csr_data, 64'd0);
        chk("rs_csr_we",    64'(out_csr_we), 64'd0);
        chk_cnt("rs_cnt", 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        chk("rs_after_valid", 64'(out_valid), 64'd0);
        chk("rs_after_addr",  64'(out_rd_addr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM→WB pipeline stage carrying a general-register write channel and a CSR write channel from the memory stage to the register file and CSR file. It replaces fixed-width, stall-by-ctrl-code stage registers with a valid/ready handshake, a 2-entry skid buffer so `in_ready` is a registered signal, and a synchronous flush. Its outputs drive the regfile/CSR write ports and the WB→ID forwarding path directly.

## Interface
Parameters:
- `XLEN`, 64, data width of both channels
- `RA_W`, 5, general-register address width
- `CA_W`, 12, CSR address width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `in_valid`  in  1  MEM stage presents an entry
- `in_ready`  out  1  stage can accept; registered, equals NOT skid-occupied
- `in_rd_addr`  in  RA_W  destination GPR
- `in_rd_we`  in  1  GPR write request
- `in_rd_data`  in  XLEN  GPR write data
- `in_csr_addr`  in  CA_W  destination CSR
- `in_csr_we`  in  1  CSR write request
- `in_csr_data`  in  XLEN  CSR write data
- `flush`  in  1  discard all held entries
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  regfile/CSR file consumes the head this cycle
- `out_rd_addr`, `out_rd_data`  out  RA_W / XLEN  head GPR address/data
- `out_rd_we`  out  1  `out_valid` AND stored `rd_we` AND `rd_addr != 0`
- `out_csr_addr`, `out_csr_data`  out  CA_W / XLEN  head CSR address/data
- `out_csr_we`  out  1  `out_valid` AND stored `csr_we`
- `retire_cnt`  out  64  committed entries (only with `MEM_WB_RETIRE_CNT_EN`)

## Operation
- accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- Two slots: head (drives `out_*`) and skid. State: EMPTY, ONE, TWO.
- EMPTY: accept → ONE, head ← in.
- ONE: accept & drain → ONE, head ← in; accept & !drain → TWO, skid ← in; !accept & drain → EMPTY; otherwise hold.
- TWO: `in_ready` = 0 (no accept possible); drain → ONE, head ← skid; otherwise hold.
- `flush` (cycle N): state → EMPTY at edge N; the cycle-N input is dropped. The head still drains in cycle N if `out_ready` (its write happens at edge N and counts as retired).
- `rst` dominates `flush`. Reset values: state EMPTY, `out_valid` 0, all `out_*` 0, `retire_cnt` 0, `in_ready` 1.
- Inputs presented while `rst` is high are discarded.
- Held slot data does not change except on the transitions listed above; `in_*` values are don't-care when `in_valid` = 0.

## Timing
- Latency: an entry accepted at edge N appears on `out_*` in cycle N+1 (EMPTY/ONE-with-drain path).
- Throughput: 1 entry/cycle while `out_ready` = 1; `in_ready` never drops in that case.
- With `out_ready` low: two entries are absorbed, then `in_ready` falls at the edge that fills the skid slot. It rises one cycle after the first drain.
- `in_ready` and all `out_*` are flop outputs or AND gates of flops; there is no combinational path from `in_*` or `out_ready` to any output.
- Forwarding consumers use `out_rd_we`/`out_rd_addr`/`out_rd_data` in the same cycle.

## Configuration
- `MEM_WB_RETIRE_CNT_EN` defined: `retire_cnt` port and a 64-bit counter are present. The counter increments by 1 on every drain and wraps at 2^64−1 → 0. It is cleared only by `rst`; `flush` does not clear it.
- Not defined: the port and counter are absent, and there is no other behavioural change.

## Structure
- Shared package `wb_pkg`: `wb_entry_t` (rd_addr, rd_we, rd_data, csr_addr, csr_we, csr_data, widths from parameters), state encoding constants `WB_EMPTY`/`WB_ONE`/`WB_TWO`.
- One sub-module, `wb_entry_reg`: a load-enabled, sync-reset register holding one `wb_entry_t`, instantiated twice (head and skid).

## Test plan
- Single entry rd=5, data=0xDEAD, `out_ready`=1 → `out_valid`, `out_rd_we`=1, addr 5, data 0xDEAD exactly one cycle later; the following cycle `out_valid` = 0.
- 8 back-to-back entries with `out_ready`=1 → 8 consecutive outputs in order, `in_ready` constantly 1, `retire_cnt` = 8.
- `out_ready`=0, 3 entries offered (A, B, C) → A and B accepted; `in_ready`=0 from the cycle after B is accepted; C is held by the source. Raise `out_ready` → output order A, B, C with no loss or duplication.
- Entry with rd=0, `rd_we`=1 together with csr 0x300, `csr_we`=1 → `out_rd_we`=0, `out_csr_we`=1, `out_csr_addr`=0x300.
- TWO state plus `flush` with `out_ready`=1 → the head drains that cycle, the skid entry is discarded, state is EMPTY next cycle, `retire_cnt` +1, `in_ready`=1.
- `rst` pulsed mid-stream while in state TWO → next cycle all outputs 0, `in_ready`=1, `retire_cnt`=0, and the input offered during reset is not seen at the output.
